// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and request legality check for the memory-stage LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_t;

  // RV32I load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // RV32I store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // A request that must be flagged instead of issued: conflicting controls,
  // an undefined size/sign code, an unsigned store, or a misaligned access.
  function automatic logic req_bad(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (rd && wr) bad = 1'b1;
    if (f3 == 3'b011 || f3[2:1] == 2'b11) bad = 1'b1;
    if (wr && f3[2]) bad = 1'b1;
    if (f3[1:0] == 2'b01 && lo[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-lane steering / enables and load lane extraction with extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_ext
);

  logic [31:0] ld_shift;

  // Store: replicate the datum across lanes and enable only the addressed bytes
  always_comb begin
    st_be    = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      2'b00: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_lanes = st_data;
      end
    endcase
  end

  // Load: move the addressed lane to bit 0, then sign- or zero-extend by size
  always_comb begin
    ld_shift = ld_data >> {ld_off, 3'b000};
    ld_ext   = 32'h0;
    case (ld_funct3)
      F3_LB:   ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_LW:   ld_ext = ld_data;
      F3_LBU:  ld_ext = {24'h0, ld_shift[7:0]};
      F3_LHU:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory-stage load/store unit on a single-outstanding valid/ready bus
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  lsu_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        any_ctl, bad, start, req_flt, expire, complete;
  logic [3:0]  st_be;
  logic [31:0] st_lanes, ld_ext;

  // Load extraction uses the latched size/offset so it cannot follow a changing EX/MEM
  lsu_align u_align (
    .st_size   (funct3[1:0]),
    .st_off    (addr[1:0]),
    .st_data   (wdata),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_data   (bus_rdata),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_ext    (ld_ext)
  );

  assign any_ctl  = mem_read | mem_write;
  assign bad      = req_bad(mem_read, mem_write, funct3, addr[1:0]);
  assign start    = (state == S_IDLE) && any_ctl && !bad;
  assign req_flt  = (state == S_IDLE) && any_ctl && bad;
  assign complete = (state == S_ACCESS) && bus_ready;
  assign expire   = (state == S_ACCESS) && !bus_ready && (cnt == LAST);

  // Next-state and stall; stall is forced low while reset is held
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ACCESS;
          stall      = 1'b1;
        end
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (bus_ready)   state_next = S_RESP;
        else if (expire) state_next = S_IDLE;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // State, wait counter, latched bus fields and the registered result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      done      <= 1'b0;
      load_data <= 32'h0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      done      <= complete;
      fault     <= req_flt | expire;
      load_data <= (complete && !bus_we) ? ld_ext : 32'h0;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= st_be;
        bus_wdata <= st_lanes;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        cnt       <= '0;
      end else if (state == S_ACCESS) begin
        if (complete || expire) bus_req <= 1'b0;
        else                    cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the RV32I pipeline. Consumes the EX/MEM pipeline register outputs (address, store data, funct3, read/write controls) and runs the access on a single-outstanding valid/ready data bus. It steers byte lanes, sign/zero-extends load data, and holds the pipeline stalled until the access completes. Misaligned, illegal or timed-out accesses are flagged instead of being issued.

## Interface
- TIMEOUT, 255: max cycles with bus_req high and no bus_ready before abort; ≥1.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_read  in  1  EX/MEM load control
- mem_write  in  1  EX/MEM store control
- funct3  in  3  access size/sign (RV32I load/store encoding)
- addr  in  32  byte address (EX/MEM ALU result)
- wdata  in  32  store data (EX/MEM register data)
- bus_req  out  1  request valid, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  32  word address {addr[31:2],2'b00}, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-steered store data, registered
- bus_ready  in  1  slave accept/complete for current request
- bus_rdata  in  32  read data, valid when bus_ready high on a read
- stall  out  1  combinational; drives EX/MEM and upstream enables low
- done  out  1  one-cycle completion pulse, registered
- load_data  out  32  extended load result, valid while done high
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, both controls high, or timeout

## Operation
- States IDLE, ACCESS, RESP.
- IDLE, no control high: nothing happens.
- IDLE, exactly one control high, legal and aligned: latch bus fields, go ACCESS; stall=1 this cycle.
- IDLE, faulting request: fault=1 next cycle, stay IDLE, no bus_req, stall=0, load_data=0.
- Fault causes: halfword with addr[0]=1; word with addr[1:0]≠0; funct3 ∈ {011,11x}, or store with funct3[2]=1; mem_read & mem_write both high.
- ACCESS: bus_req=1, stall=1. Fields held constant until bus_ready.
  - bus_ready=1: capture extended rdata (reads), go RESP, drop bus_req next cycle.
  - TIMEOUT cycles without bus_ready: drop bus_req, fault=1, go IDLE.
- RESP: done=1, stall=0, inputs ignored (same instruction still on EX/MEM); next state IDLE.
- Store steering: SB be=1<<addr[1:0], byte replicated on all lanes; SH be=0011/1100 by addr[1], halfword replicated; SW be=1111.
- Load extract: lane = rdata >> 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. load_data=0 for stores.

## Timing
- Reset: state IDLE, wait counter 0, every registered output 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, done, load_data, fault). stall is 0 while in reset.
- Reset mid-ACCESS: bus_req low the cycle after the reset edge; the in-flight access is abandoned with no done and no fault.
- Latency, zero-wait slave: request at cycle 0, bus_req at 1, bus_ready at 1, done at 2. Stall covers cycles 0–1. Each wait state adds one cycle.
- bus_ready is ignored outside ACCESS.
- Counter is 8 bits wide minimum, sized $clog2(TIMEOUT+1). It clears on ACCESS entry and increments each ACCESS cycle without bus_ready. Abort when count reaches TIMEOUT-1 with no bus_ready that cycle.
- bus_ready on the timeout cycle: completion wins, no fault.

## Structure
- Package lsu_pkg: state enum; funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Sub-module lsu_align: combinational store lane steering / be generation and load extraction.

## Test plan
- SW addr=0x1000 wdata=0xDEADBEEF, bus_ready at 1: bus_addr=0x1000, be=1111, bus_wdata=0xDEADBEEF; done at cycle 2, stall cycles 0–1.
- LB addr=0x2003, rdata=0x80FF7F01, 3 wait states: load_data=0xFFFFFF80, done at cycle 5. Repeat as LBU: load_data=0x00000080.
- SH addr=0x3002 wdata=0x0000ABCD: be=1100, bus_wdata=0xABCDABCD. LH addr=0x3001: fault pulse, no bus_req, stall=0.
- TIMEOUT=4, bus_ready never: bus_req high exactly 4 cycles, then fault=1, state IDLE, no done.
- Reset asserted in ACCESS cycle 2: bus_req=0 and all outputs 0 next cycle. A following LW completes normally.
- Back-to-back LW 0x10, SW 0x14 with zero-wait slave: each request issued exactly once; done at cycles 2 and 5.
